// File: rtl/mcu_bus_pkg.sv
// Shared MCU bus definitions: FSM encoding, command/data flag values and the
// default strobe timing used by both the transmit and the msgpu receive side.
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } mcu_bus_state_e;

  localparam logic MCU_BUS_COMMAND = 1'b1;
  localparam logic MCU_BUS_DATA    = 1'b0;

  localparam int MCU_BUS_SETUP_CYCLES = 2;
  localparam int MCU_BUS_HIGH_CYCLES  = 4;
  localparam int MCU_BUS_HOLD_CYCLES  = 2;
  localparam int MCU_BUS_FIFO_DEPTH   = 8;

  // Buffer entry is {command flag, byte}
  localparam int MCU_BUS_ENTRY_W = 9;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_bus_tx_fifo.sv
// Synchronous FIFO for queued MCU bus entries; full/empty come straight from
// the registered pointers (extra wrap bit distinguishes full from empty).
module mcu_bus_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mcu_bus_transmitter.sv
// MCU bus driver: buffers command/data bytes and strobes them out with
// SETUP/HIGH/HOLD timing. Define MCU_BUS_TX_FIFO_EN for a FIFO buffer.
module mcu_bus_transmitter
  import mcu_bus_pkg::*;
#(
  parameter int SETUP_CYCLES = MCU_BUS_SETUP_CYCLES,
  parameter int HIGH_CYCLES  = MCU_BUS_HIGH_CYCLES,
  parameter int HOLD_CYCLES  = MCU_BUS_HOLD_CYCLES,
  parameter int FIFO_DEPTH   = MCU_BUS_FIFO_DEPTH
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_command,
  output logic       mcu_bus_clock,
  output logic [7:0] mcu_bus,
  output logic       mcu_bus_command_data,
  output logic       busy
);

  localparam int CW = $clog2(max3(SETUP_CYCLES, HIGH_CYCLES, HOLD_CYCLES)) + 1;

  if (SETUP_CYCLES < 1 || HIGH_CYCLES < 1 || HOLD_CYCLES < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("mcu_bus_transmitter: illegal timing or FIFO_DEPTH parameter");
  end

  mcu_bus_state_e             state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       strobe_q, strobe_d;
  logic                       push, pop, last;
  logic                       buf_full, buf_empty;
  logic [MCU_BUS_ENTRY_W-1:0] buf_out;

  assign tx_ready = ~reset & ~buf_full;
  assign push     = tx_valid & tx_ready;

`ifdef MCU_BUS_TX_FIFO_EN
  mcu_bus_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MCU_BUS_ENTRY_W)
  ) u_fifo (
    .clk       (system_clock),
    .reset     (reset),
    .push      (push),
    .push_data ({tx_command, tx_data}),
    .pop       (pop),
    .pop_data  (buf_out),
    .full      (buf_full),
    .empty     (buf_empty)
  );
`else
  // Single holding register: push only when empty, pop only when full.
  logic [MCU_BUS_ENTRY_W-1:0] hold_q;
  logic                       hold_full;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_q    <= {tx_command, tx_data};
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  assign buf_out   = hold_q;
  assign buf_full  = hold_full;
  assign buf_empty = ~hold_full;
`endif

  assign last = (cnt_q == CW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          cnt_d   = CW'(SETUP_CYCLES);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (last) begin
          strobe_d = 1'b1;
          cnt_d    = CW'(HIGH_CYCLES);
          state_d  = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (last) begin
          cnt_d   = CW'(HOLD_CYCLES);
          state_d = ST_HOLD;
        end else begin
          strobe_d = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        // Chain straight into the next byte so back-to-back has no idle gap.
        if (last) begin
          if (!buf_empty) begin
            pop     = 1'b1;
            cnt_d   = CW'(SETUP_CYCLES);
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      cnt_q                <= '0;
      strobe_q             <= 1'b0;
      mcu_bus              <= '0;
      mcu_bus_command_data <= MCU_BUS_DATA;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      if (pop) begin
        mcu_bus              <= buf_out[7:0];
        mcu_bus_command_data <= buf_out[8];
      end
    end
  end

  assign mcu_bus_clock = strobe_q;
  assign busy          = (state_q != ST_IDLE) | ~buf_empty;

endmodule

// File: tb/tb_mcu_bus_transmitter.sv
// Directed bench for mcu_bus_transmitter: default-timing DUT plus a 1/1/1
// timing DUT, each with a strobe-edge receiver model and bus-stability monitor.
module tb_mcu_bus_transmitter;
  import mcu_bus_pkg::*;

  logic       system_clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0, tx_command = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, mcu_bus_clock, mcu_bus_command_data, busy;
  logic [7:0] mcu_bus;

  logic       f_valid = 1'b0, f_command = 1'b0;
  logic [7:0] f_data = 8'h00;
  logic       f_ready, f_strobe, f_flag, f_busy;
  logic [7:0] f_bus;

  int checks = 0, errors = 0, cyc = 0;
  int bus_changes = 0, f_bus_changes = 0;
  int rise_q[$], f_rise_q[$];
  logic [8:0] rx_q[$], f_rx_q[$];
  logic       strobe_prev = 1'b0, f_strobe_prev = 1'b0;
  logic [8:0] bus_prev = '0, f_bus_prev = '0;

  always #5 system_clock = ~system_clock;

  mcu_bus_transmitter u_dut (
    .system_clock         (system_clock),
    .reset                (reset),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .tx_data              (tx_data),
    .tx_command           (tx_command),
    .mcu_bus_clock        (mcu_bus_clock),
    .mcu_bus              (mcu_bus),
    .mcu_bus_command_data (mcu_bus_command_data),
    .busy                 (busy)
  );

  mcu_bus_transmitter #(
    .SETUP_CYCLES (1),
    .HIGH_CYCLES  (1),
    .HOLD_CYCLES  (1)
  ) u_fast (
    .system_clock         (system_clock),
    .reset                (reset),
    .tx_valid             (f_valid),
    .tx_ready             (f_ready),
    .tx_data              (f_data),
    .tx_command           (f_command),
    .mcu_bus_clock        (f_strobe),
    .mcu_bus              (f_bus),
    .mcu_bus_command_data (f_flag),
    .busy                 (f_busy)
  );

  // Receiver model: capture {flag, byte} on each strobe rise; flag any bus
  // movement while the strobe stays high.
  always begin
    @(posedge system_clock);
    cyc++;
    #1;
    if (mcu_bus_clock && !strobe_prev) begin
      rise_q.push_back(cyc);
      rx_q.push_back({mcu_bus_command_data, mcu_bus});
    end
    if (mcu_bus_clock && strobe_prev && ({mcu_bus_command_data, mcu_bus} != bus_prev))
      bus_changes++;
    if (f_strobe && !f_strobe_prev) begin
      f_rise_q.push_back(cyc);
      f_rx_q.push_back({f_flag, f_bus});
    end
    if (f_strobe && f_strobe_prev && ({f_flag, f_bus} != f_bus_prev))
      f_bus_changes++;
    strobe_prev   = mcu_bus_clock;
    bus_prev      = {mcu_bus_command_data, mcu_bus};
    f_strobe_prev = f_strobe;
    f_bus_prev    = {f_flag, f_bus};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic send(input bit fast, input logic [7:0] d, input logic c, output int acc);
    int n = 0;
    if (fast) begin f_valid = 1'b1; f_data = d; f_command = c; end
    else      begin tx_valid = 1'b1; tx_data = d; tx_command = c; end
    while (!(fast ? f_ready : tx_ready) && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    @(posedge system_clock);
    #1;
    acc = cyc;
    if (fast) f_valid = 1'b0;
    else      tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit fast);
    int n = 0;
    while ((fast ? f_busy : busy) && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) chk("idle_timeout", n, 0);
  endtask

  initial begin
    int acc[10];
    int a0, n;

    // Reset values
    tick(3);
    chk("rst_strobe", mcu_bus_clock, 0);
    chk("rst_bus", mcu_bus, 0);
    chk("rst_flag", mcu_bus_command_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", tx_ready, 1);

    // Single command byte timing
    rx_q.delete(); rise_q.delete();
    send(0, 8'hA5, MCU_BUS_COMMAND, a0);
    tick(1);
    chk("t1_bus", mcu_bus, 8'hA5);
    chk("t1_flag", mcu_bus_command_data, 1);
    chk("t1_busy", busy, 1);
    chk("t1_strobe_e1", mcu_bus_clock, 0);
    tick(1); chk("t1_setup_low", mcu_bus_clock, 0);
    tick(1); chk("t1_rise", mcu_bus_clock, 1);
    tick(3); chk("t1_high_end", mcu_bus_clock, 1);
    tick(1); chk("t1_fall", mcu_bus_clock, 0);
    chk("t1_bus_hold", mcu_bus, 8'hA5);
    tick(1); chk("t1_hold_busy", busy, 1);
    tick(1); chk("t1_idle_busy", busy, 0);
    chk("t1_bus_kept", mcu_bus, 8'hA5);
    chk("t1_rx_n", rx_q.size(), 1);
    chk("t1_rx", (rx_q.size() > 0) ? rx_q[0] : 9'h000, {1'b1, 8'hA5});
    chk("t1_rise_cyc", (rise_q.size() > 0) ? rise_q[0] - a0 : 0, 3);

    // Back-to-back data burst 0x01..0x08
    rx_q.delete(); rise_q.delete();
    for (int i = 0; i < 8; i++) send(0, 8'(i + 1), MCU_BUS_DATA, acc[i]);
    wait_idle(0);
    chk("t2_rx_n", rx_q.size(), 8);
    for (int i = 1; i < 8; i++)
      chk("t2_gap", (i < rise_q.size()) ? rise_q[i] - rise_q[i-1] : 0, 8);
    for (int i = 0; i < 8; i++)
      chk("t2_rx", (i < rx_q.size()) ? rx_q[i] : 9'h1FF, {1'b0, 8'(i + 1)});

`ifdef MCU_BUS_TX_FIFO_EN
    // FIFO fills while the first byte is on the bus; 10th push waits for a pop
    rx_q.delete();
    for (int i = 0; i < 9; i++) send(0, 8'(8'h20 + i), MCU_BUS_DATA, acc[i]);
    chk("t3_full_ready", tx_ready, 0);
    send(0, 8'h29, MCU_BUS_DATA, acc[9]);
    for (int i = 1; i < 9; i++) chk("t3_acc", acc[i] - acc[0], i);
    chk("t3_acc_after_pop", acc[9] - acc[0], 10);
    wait_idle(0);
    chk("t3_rx_n", rx_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("t3_rx", (i < rx_q.size()) ? rx_q[i] : 9'h1FF, {1'b0, 8'(8'h20 + i)});
`else
    // Holding register blocks the second push until the first enters SETUP
    rx_q.delete();
    send(0, 8'h10, MCU_BUS_DATA, acc[0]);
    chk("t3_ready_low", tx_ready, 0);
    send(0, 8'h11, MCU_BUS_DATA, acc[1]);
    chk("t3_acc_gap", acc[1] - acc[0], 2);
    wait_idle(0);
    chk("t3_rx_n", rx_q.size(), 2);
    chk("t3_rx0", (rx_q.size() > 0) ? rx_q[0] : 9'h1FF, {1'b0, 8'h10});
    chk("t3_rx1", (rx_q.size() > 1) ? rx_q[1] : 9'h1FF, {1'b0, 8'h11});
`endif

    // Reset while the strobe is high
    send(0, 8'h3C, MCU_BUS_COMMAND, a0);
    n = 0;
    while (!mcu_bus_clock && n < 50) begin tick(1); n++; end
    if (n >= 50) chk("t4_strobe_timeout", n, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("t4_strobe", mcu_bus_clock, 0);
    chk("t4_bus", mcu_bus, 0);
    chk("t4_flag", mcu_bus_command_data, 0);
    chk("t4_busy", busy, 0);
    reset = 1'b0;
    #1;
    rx_q.delete();
    send(0, 8'h5A, MCU_BUS_DATA, a0);
    wait_idle(0);
    chk("t4_rx_n", rx_q.size(), 1);
    chk("t4_rx", (rx_q.size() > 0) ? rx_q[0] : 9'h1FF, {1'b0, 8'h5A});

    // Minimum timing: 3-cycle byte period
    f_rx_q.delete(); f_rise_q.delete();
    for (int i = 0; i < 4; i++) send(1, 8'(8'h81 + i), i[0], acc[i]);
    wait_idle(1);
    chk("t5_rx_n", f_rx_q.size(), 4);
    for (int i = 1; i < 4; i++)
      chk("t5_gap", (i < f_rise_q.size()) ? f_rise_q[i] - f_rise_q[i-1] : 0, 3);
    for (int i = 0; i < 4; i++)
      chk("t5_rx", (i < f_rx_q.size()) ? f_rx_q[i] : 9'h1FF, {i[0], 8'(8'h81 + i)});
    chk("t5_bus_stable", f_bus_changes, 0);
    chk("bus_stable", bus_changes, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
